load_enable_reg: RTL and testbench
==================================

Name: load_enable_reg

Overview:
- Parameterised storage register with a two-qualifier write: new data is captured only when both `load` (per-register select) and `enable` (global write strobe) are high.
- One instance per register-file entry.
- All eight entries share the `enable` and `inp` buses; each entry has its own `load` line.
- Also provides status outputs: `valid`, `updated` and `changed`.

Parameters:
- WIDTH, 16, data width in bits.
- RESET_VAL, 0 (WIDTH bits), value of `out` after reset.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst  input  1  synchronous active-high reset.
- load  input  1  register select; write only when high.
- enable  input  1  global write strobe; write only when high.
- inp  input  WIDTH  write data.
- out  output  WIDTH  stored value, registered.
- valid  output  1  high once the register has been written since reset.
- updated  output  1  one-cycle pulse, the cycle after a write commits.
- changed  output  1  one-cycle pulse, the cycle after a write whose `inp` differed from the previous `out`.
- parity  output  1  present only with LER_PARITY_EN; see Optional Feature.

Behaviour:
- Write condition: `we = load & enable`, sampled at posedge clk.
- Write latency:
  - When `we` is high at edge N, `out` equals the sampled `inp` after edge N.
  - `out` is visible during cycle N+1.
  - No combinational path from `inp` to `out`.
- Hold cases: `out` keeps its value when any of these is true:
  - `load=0`
  - `enable=0`
  - both are 0
- Reset:
  - `rst=1` at posedge clk sets `out=RESET_VAL`, `valid=0`, `updated=0`, `changed=0`.
  - Reset has priority over a simultaneous write; the write is discarded.
  - Reset asserted mid-sequence takes effect at that edge; the next write after `rst` falls behaves normally.
- valid:
  - Set to 1 on the first committed write.
  - Stays 1 until reset.
  - Writing RESET_VAL still sets `valid`.
- updated: registered copy of `we`; high for exactly one cycle per committed write.
- Back-to-back writes:
  - `updated` stays high continuously.
  - `out` tracks `inp` one cycle later.
- changed:
  - Registered `(we && inp != out)`, using the pre-write `out`.
  - Writing the current value gives `updated=1`, `changed=0`.
- X/unknown on `load` or `enable` is not supported; drivers must hold them at 0 when idle.
- Full-width writes only; no partial or byte-lane writes.
- No wrap-around or overflow semantics: pure storage.

Optional Feature:
- Macro: LER_PARITY_EN.
- Defined:
  - Adds output `parity` (1 bit), registered even parity of the stored word: XOR-reduction of `out`.
  - Updated in the same edge as `out`.
  - Reset value is the XOR of RESET_VAL (0 for the default).
- Not defined: `parity` port and its logic are absent; the remaining behaviour is unchanged.

Test Plan:
- Reset: drive `rst=1` for 2 cycles with `load=1`, `enable=1`, `inp=16'hFFFF` -> `out=16'h0000`, `valid=0`, `updated=0`, `changed=0`.
- Qualified write:
  - Drive `load=1`, `enable=1`, `inp=16'h1234` for one cycle -> next cycle `out=16'h1234`, `valid=1`, `updated=1`, `changed=1`.
  - Following idle cycle -> `updated=0`, `changed=0`.
- Gating: with `out=16'h1234`, apply `inp=16'hABCD` with (`load=1`, `enable=0`), then (`load=0`, `enable=1`), then (0, 0) -> `out` stays `16'h1234`, `updated=0` throughout.
- Same-value write: write `16'h1234` again -> `updated=1`, `changed=0`, `out=16'h1234`.
- Back-to-back writes: write `16'h0001`, `16'h0002`, `16'h0003` on consecutive edges -> `out` follows one cycle later, `updated` high for 3 consecutive cycles.
- Reset vs write and parity:
  - Assert `rst=1` together with a write of `16'h5555` -> `out=16'h0000`, `valid=0`.
  - With LER_PARITY_EN, writing `16'h0007` -> `parity=1`; writing `16'h0003` -> `parity=0`.

Source files
------------

// File: rtl/load_enable_reg_if.sv
// Bus bundle for one register-file entry: write qualifiers and data in, stored word and status out.
// The parity signal exists only when LER_PARITY_EN is defined.
interface load_enable_reg_if #(
  parameter int WIDTH = 16
);
  logic             load;
  logic             enable;
  logic [WIDTH-1:0] inp;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic             updated;
  logic             changed;
`ifdef LER_PARITY_EN
  logic             parity;
`endif

  modport master (
    output load, enable, inp,
`ifdef LER_PARITY_EN
    input  parity,
`endif
    input  out, valid, updated, changed
  );

  modport slave (
    input  load, enable, inp,
`ifdef LER_PARITY_EN
    output parity,
`endif
    output out, valid, updated, changed
  );
endinterface

// File: rtl/load_enable_reg.sv
// Storage register written only when load and enable are both high, with valid/updated/changed status.
// Optional registered even-parity output is enabled with the LER_PARITY_EN macro.
module load_enable_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               clk,
  input logic               rst,
  load_enable_reg_if.slave  bus
);

  logic             we;
  logic [WIDTH-1:0] out_q;
  logic             valid_q;
  logic             updated_q;
  logic             changed_q;

  assign we = bus.load & bus.enable;

  // changed compares against the pre-write value held in out_q
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= RESET_VAL;
      valid_q   <= 1'b0;
      updated_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      updated_q <= we;
      changed_q <= we && (bus.inp != out_q);
      if (we) begin
        out_q   <= bus.inp;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.out     = out_q;
  assign bus.valid   = valid_q;
  assign bus.updated = updated_q;
  assign bus.changed = changed_q;

`ifdef LER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= ^RESET_VAL;
    end else if (we) begin
      parity_q <= ^bus.inp;
    end
  end

  assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_load_enable_reg.sv
// Testbench for load_enable_reg: directed vector table followed by randomized traffic against a reference model.
module tb_load_enable_reg;

  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] RESET_VAL = '0;

  logic clk;
  logic rst;

  load_enable_reg_if #(.WIDTH(WIDTH)) bus ();

  load_enable_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             load;
    logic             enable;
    logic [WIDTH-1:0] inp;
    logic [WIDTH-1:0] exp_out;
    logic             exp_valid;
    logic             exp_updated;
    logic             exp_changed;
    logic             exp_parity;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input int idx, input logic [WIDTH-1:0] got,
                     input logic [WIDTH-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst        = r;
    bus.load   = l;
    bus.enable = e;
    bus.inp    = d;
    @(posedge clk);
    #1;
  endtask

  // reference model state
  logic [WIDTH-1:0] m_out;
  int               m_writes;
  logic             m_updated;
  logic             m_changed;

  initial begin
    rst        = 1'b1;
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    bus.inp    = '0;

    //            rst  ld   en   inp       out       v    u    c    p
    vecs[0]  = '{1'b1,1'b1,1'b1,16'hFFFF,16'h0000,1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b1,16'hFFFF,16'h0000,1'b0,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b1,16'h1234,16'h1234,1'b1,1'b1,1'b1,1'b1};
    vecs[3]  = '{1'b0,1'b0,1'b0,16'h0000,16'h1234,1'b1,1'b0,1'b0,1'b1};
    vecs[4]  = '{1'b0,1'b1,1'b0,16'hABCD,16'h1234,1'b1,1'b0,1'b0,1'b1};
    vecs[5]  = '{1'b0,1'b0,1'b1,16'hABCD,16'h1234,1'b1,1'b0,1'b0,1'b1};
    vecs[6]  = '{1'b0,1'b0,1'b0,16'hABCD,16'h1234,1'b1,1'b0,1'b0,1'b1};
    vecs[7]  = '{1'b0,1'b1,1'b1,16'h1234,16'h1234,1'b1,1'b1,1'b0,1'b1};
    vecs[8]  = '{1'b0,1'b1,1'b1,16'h0001,16'h0001,1'b1,1'b1,1'b1,1'b1};
    vecs[9]  = '{1'b0,1'b1,1'b1,16'h0002,16'h0002,1'b1,1'b1,1'b1,1'b1};
    vecs[10] = '{1'b0,1'b1,1'b1,16'h0003,16'h0003,1'b1,1'b1,1'b1,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,16'h0000,16'h0003,1'b1,1'b0,1'b0,1'b0};
    vecs[12] = '{1'b1,1'b1,1'b1,16'h5555,16'h0000,1'b0,1'b0,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b1,1'b1,16'h0000,16'h0000,1'b1,1'b1,1'b0,1'b0};
    vecs[14] = '{1'b0,1'b1,1'b1,16'h0007,16'h0007,1'b1,1'b1,1'b1,1'b1};
    vecs[15] = '{1'b0,1'b1,1'b1,16'h0003,16'h0003,1'b1,1'b1,1'b1,1'b0};

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].enable, vecs[i].inp);
      chk("out",     i, bus.out,           vecs[i].exp_out);
      chk("valid",   i, WIDTH'(bus.valid),   WIDTH'(vecs[i].exp_valid));
      chk("updated", i, WIDTH'(bus.updated), WIDTH'(vecs[i].exp_updated));
      chk("changed", i, WIDTH'(bus.changed), WIDTH'(vecs[i].exp_changed));
`ifdef LER_PARITY_EN
      chk("parity",  i, WIDTH'(bus.parity),  WIDTH'(vecs[i].exp_parity));
`endif
    end

    // reset in the middle of back-to-back writes, then a write right after reset falls
    drive(1'b0, 1'b1, 1'b1, 16'h00A0);
    drive(1'b1, 1'b1, 1'b1, 16'h00A1);
    chk("mid_rst_out", 0, bus.out, RESET_VAL);
    chk("mid_rst_upd", 0, WIDTH'(bus.updated), '0);
    drive(1'b0, 1'b1, 1'b1, 16'h00A2);
    chk("post_rst_out",   0, bus.out, 16'h00A2);
    chk("post_rst_valid", 0, WIDTH'(bus.valid), WIDTH'(1'b1));
    chk("post_rst_chg",   0, WIDTH'(bus.changed), WIDTH'(1'b1));

    // randomized traffic; model tracks the spec rules directly
    m_out     = 16'h00A2;
    m_writes  = 1;
    m_updated = 1'b1;
    m_changed = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic r, l, e;
      logic [WIDTH-1:0] d;
      r = ($urandom_range(0, 19) == 0);
      l = $urandom_range(0, 1);
      e = $urandom_range(0, 1);
      d = ($urandom_range(0, 3) == 0) ? m_out : WIDTH'($urandom);
      if (r) begin
        m_out     = RESET_VAL;
        m_writes  = 0;
        m_updated = 1'b0;
        m_changed = 1'b0;
      end else if (l && e) begin
        m_changed = (d != m_out);
        m_updated = 1'b1;
        m_out     = d;
        m_writes++;
      end else begin
        m_changed = 1'b0;
        m_updated = 1'b0;
      end
      drive(r, l, e, d);
      chk("rnd_out",     n, bus.out, m_out);
      chk("rnd_valid",   n, WIDTH'(bus.valid),   WIDTH'(m_writes > 0));
      chk("rnd_updated", n, WIDTH'(bus.updated), WIDTH'(m_updated));
      chk("rnd_changed", n, WIDTH'(bus.changed), WIDTH'(m_changed));
`ifdef LER_PARITY_EN
      chk("rnd_parity",  n, WIDTH'(bus.parity),  WIDTH'($countones(m_out) % 2));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
